// File: rtl/wb_pkg.sv
// Shared constants, write-back entry layout and thread decode helper
// for the 4-thread register bank write-back path.
package wb_pkg;

    localparam int THREADS    = 4;
    localparam int TID_W      = 2;
    localparam int RADDR_W    = 5;
    localparam int WB_D_WIDTH = 64;

    typedef struct packed {
        logic [TID_W-1:0]      tid;
        logic [RADDR_W-1:0]    rd;
        logic [WB_D_WIDTH-1:0] data;
    } wb_entry_t;

    function automatic logic [THREADS-1:0] tid_to_onehot(input logic [TID_W-1:0] tid);
        logic [THREADS-1:0] oh;
        oh      = '0;
        oh[tid] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for accelerator write-back entries; no bypass, so a
// pushed entry appears at the head one cycle later.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = wb_entry_t,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  entry_t           wr_entry,
    output entry_t           rd_entry,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign rd_entry = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Power-of-two depth lets the pointers wrap naturally.
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_entry;
    end

endmodule

// File: rtl/wb_arbiter_x4.sv
// Merges pipeline WB (priority) and buffered accelerator results into one
// registered register-file write per cycle, with starvation-driven stall.
module wb_arbiter_x4
    import wb_pkg::*;
#(
    parameter int D_WIDTH      = 64,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pipe_valid,
    input  logic [1:0]         pipe_thread,
    input  logic [4:0]         pipe_rd,
    input  logic [D_WIDTH-1:0] pipe_data,
    input  logic               acc_valid,
    output logic               acc_ready,
    input  logic [1:0]         acc_thread,
    input  logic [4:0]         acc_rd,
    input  logic [D_WIDTH-1:0] acc_data,
    output logic               stall_req,
    output logic [D_WIDTH-1:0] data_WB,
    output logic               ctrl_WB,
    output logic [4:0]         reg_wraddr,
    output logic [3:0]         thread_sel_WB,
    output logic               proto_err
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [TID_W-1:0]   tid;
        logic [RADDR_W-1:0] rd;
        logic [D_WIDTH-1:0] data;
    } entry_t;

    entry_t             acc_entry, head_entry, grant_entry;
    logic               fifo_full, fifo_empty, fifo_push, fifo_pop, grant_valid;
    logic [CNT_W-1:0]   fifo_count;

    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                stall_q, stall_d;
    logic                proto_q, proto_d;
    logic                ctrl_q, ctrl_d;
    logic [THREADS-1:0]  tsel_q, tsel_d;
    logic [RADDR_W-1:0]  waddr_q, waddr_d;
    logic [D_WIDTH-1:0]  data_q, data_d;

    assign acc_entry = '{tid: acc_thread, rd: acc_rd, data: acc_data};

    wb_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .wr_entry (acc_entry),
        .rd_entry (head_entry),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        fifo_push   = acc_valid && !fifo_full;
        fifo_pop    = !pipe_valid && !fifo_empty;
        grant_valid = pipe_valid || fifo_pop;
        grant_entry = pipe_valid ? '{tid: pipe_thread, rd: pipe_rd, data: pipe_data} : head_entry;

        // x0 writes still consume their slot but never reach the bank.
        ctrl_d  = grant_valid && (grant_entry.rd != '0);
        tsel_d  = '0;
        waddr_d = waddr_q;
        data_d  = data_q;
        if (ctrl_d) begin
            tsel_d  = tid_to_onehot(grant_entry.tid);
            waddr_d = grant_entry.rd;
            data_d  = grant_entry.data;
        end

        starve_d = starve_q;
        if (fifo_count == '0 || fifo_pop)
            starve_d = '0;
        else if (starve_q != STARVE_W'(STARVE_LIMIT))
            starve_d = starve_q + 1'b1;

        stall_d = (starve_d == STARVE_W'(STARVE_LIMIT));
        proto_d = proto_q || (pipe_valid && stall_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
            stall_q  <= 1'b0;
            proto_q  <= 1'b0;
            ctrl_q   <= 1'b0;
            tsel_q   <= '0;
            waddr_q  <= '0;
            data_q   <= '0;
        end else begin
            starve_q <= starve_d;
            stall_q  <= stall_d;
            proto_q  <= proto_d;
            ctrl_q   <= ctrl_d;
            tsel_q   <= tsel_d;
            waddr_q  <= waddr_d;
            data_q   <= data_d;
        end
    end

    assign acc_ready     = !fifo_full;
    assign stall_req     = stall_q;
    assign proto_err     = proto_q;
    assign ctrl_WB       = ctrl_q;
    assign thread_sel_WB = tsel_q;
    assign reg_wraddr    = waddr_q;
    assign data_WB       = data_q;

endmodule

// File: tb/tb_wb_arbiter_x4.sv
// Directed bench for wb_arbiter_x4: a reference model predicts each cycle's
// write-back into a scoreboard queue that is drained after every clock edge.
module tb_wb_arbiter_x4;

    localparam int DW = 64;
    localparam int FD = 4;
    localparam int SL = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          pipe_valid;
    logic [1:0]    pipe_thread;
    logic [4:0]    pipe_rd;
    logic [DW-1:0] pipe_data;
    logic          acc_valid;
    logic          acc_ready;
    logic [1:0]    acc_thread;
    logic [4:0]    acc_rd;
    logic [DW-1:0] acc_data;
    logic          stall_req;
    logic [DW-1:0] data_WB;
    logic          ctrl_WB;
    logic [4:0]    reg_wraddr;
    logic [3:0]    thread_sel_WB;
    logic          proto_err;

    always #5 clk = ~clk;

    wb_arbiter_x4 #(.D_WIDTH(DW), .FIFO_DEPTH(FD), .STARVE_LIMIT(SL)) dut (
        .clk           (clk),
        .reset         (reset),
        .pipe_valid    (pipe_valid),
        .pipe_thread   (pipe_thread),
        .pipe_rd       (pipe_rd),
        .pipe_data     (pipe_data),
        .acc_valid     (acc_valid),
        .acc_ready     (acc_ready),
        .acc_thread    (acc_thread),
        .acc_rd        (acc_rd),
        .acc_data      (acc_data),
        .stall_req     (stall_req),
        .data_WB       (data_WB),
        .ctrl_WB       (ctrl_WB),
        .reg_wraddr    (reg_wraddr),
        .thread_sel_WB (thread_sel_WB),
        .proto_err     (proto_err)
    );

    typedef struct {
        logic          ctrl;
        logic [3:0]    tsel;
        logic [4:0]    addr;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct {
        logic [1:0]    tid;
        logic [4:0]    rd;
        logic [DW-1:0] data;
    } ent_t;

    exp_t exp_q[$];
    ent_t mq[$];

    int            total = 0;
    int            bad   = 0;
    int            m_starve = 0;
    logic          m_stall = 1'b0;
    logic          m_proto = 1'b0;
    logic [4:0]    m_addr = '0;
    logic [DW-1:0] m_data = '0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Predict this cycle's outcome from the current inputs, clock once, then compare.
    task automatic step();
        exp_t e;
        ent_t g;
        bit   push, pop, gv;
        e = '{ctrl: 1'b0, tsel: 4'b0, addr: m_addr, data: m_data};
        if (reset) begin
            mq.delete();
            m_starve = 0;
            m_stall  = 1'b0;
            m_proto  = 1'b0;
            m_addr   = '0;
            m_data   = '0;
            e.addr   = '0;
            e.data   = '0;
        end else begin
            push = acc_valid && (mq.size() < FD);
            pop  = !pipe_valid && (mq.size() > 0);
            gv   = pipe_valid || pop;
            g    = '{tid: 2'd0, rd: 5'd0, data: '0};
            if (pipe_valid) g = '{tid: pipe_thread, rd: pipe_rd, data: pipe_data};
            else if (pop)   g = mq[0];
            if (gv && g.rd != 5'd0) begin
                e.ctrl = 1'b1;
                e.tsel = 4'b0001 << g.tid;
                e.addr = g.rd;
                e.data = g.data;
                m_addr = g.rd;
                m_data = g.data;
            end
            m_proto = m_proto || (pipe_valid && m_stall);
            if (mq.size() == 0 || pop) m_starve = 0;
            else if (m_starve < SL)    m_starve++;
            m_stall = (m_starve == SL);
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back('{tid: acc_thread, rd: acc_rd, data: acc_data});
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("ctrl_WB", {63'd0, ctrl_WB}, {63'd0, e.ctrl});
        chk("thread_sel_WB", {60'd0, thread_sel_WB}, {60'd0, e.tsel});
        chk("reg_wraddr", {59'd0, reg_wraddr}, {59'd0, e.addr});
        chk("data_WB", data_WB, e.data);
        chk("acc_ready", {63'd0, acc_ready}, {63'd0, mq.size() < FD});
        chk("stall_req", {63'd0, stall_req}, {63'd0, m_stall});
        chk("proto_err", {63'd0, proto_err}, {63'd0, m_proto});
    endtask

    task automatic set_pipe(input logic v, input logic [1:0] t, input logic [4:0] rd, input logic [DW-1:0] d);
        pipe_valid = v; pipe_thread = t; pipe_rd = rd; pipe_data = d;
    endtask

    task automatic set_acc(input logic v, input logic [1:0] t, input logic [4:0] rd, input logic [DW-1:0] d);
        acc_valid = v; acc_thread = t; acc_rd = rd; acc_data = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        set_pipe(1'b0, 2'd0, 5'd0, '0);
        set_acc(1'b0, 2'd0, 5'd0, '0);
        step();
        step();
        chk("reset_ctrl", {63'd0, ctrl_WB}, 64'd0);
        chk("reset_acc_ready", {63'd0, acc_ready}, 64'd1);

        // Single pipeline write.
        reset = 1'b0;
        set_pipe(1'b1, 2'd2, 5'd7, 64'hDEAD);
        step();
        chk("pipe_tsel", {60'd0, thread_sel_WB}, 64'b0100);
        chk("pipe_data", data_WB, 64'hDEAD);
        set_pipe(1'b0, 2'd0, 5'd0, '0);
        step();

        // Fill the FIFO while the pipeline occupies the port.
        for (int i = 0; i < 4; i++) begin
            set_pipe(1'b1, 2'd1, 5'(10 + i), 64'(32'h1000 + i));
            set_acc(1'b1, 2'(i), 5'(1 + i), 64'(32'hA000 + i));
            step();
        end
        chk("acc_ready_full", {63'd0, acc_ready}, 64'd0);
        set_acc(1'b1, 2'd0, 5'd9, 64'hBEEF);
        step();
        set_pipe(1'b0, 2'd0, 5'd0, '0);
        step();
        step();
        set_acc(1'b0, 2'd0, 5'd0, '0);
        for (int i = 0; i < 5; i++) step();

        // Starvation: one entry, pipeline busy until stall_req rises.
        set_pipe(1'b1, 2'd3, 5'd15, 64'h55);
        set_acc(1'b1, 2'd2, 5'd21, 64'hC0FFEE);
        step();
        set_acc(1'b0, 2'd0, 5'd0, '0);
        n = 0;
        while (!stall_req && n < SL + 4) begin
            step();
            n++;
        end
        chk("stall_latency", 64'(n + 1), 64'(SL + 1));
        set_pipe(1'b0, 2'd0, 5'd0, '0);
        step();
        chk("drain_addr", {59'd0, reg_wraddr}, 64'd21);
        step();
        chk("stall_cleared", {63'd0, stall_req}, 64'd0);

        // x0 destinations from both sources.
        set_pipe(1'b1, 2'd1, 5'd0, 64'h11);
        set_acc(1'b1, 2'd2, 5'd0, 64'h22);
        step();
        set_pipe(1'b0, 2'd0, 5'd0, '0);
        set_acc(1'b0, 2'd0, 5'd0, '0);
        step();
        step();
        chk("x0_no_write", {63'd0, ctrl_WB}, 64'd0);

        // Protocol violation: keep the pipeline writing through stall_req.
        set_pipe(1'b1, 2'd0, 5'd3, 64'h33);
        set_acc(1'b1, 2'd1, 5'd4, 64'h44);
        step();
        set_acc(1'b0, 2'd0, 5'd0, '0);
        n = 0;
        while (!stall_req && n < SL + 4) begin
            step();
            n++;
        end
        set_pipe(1'b1, 2'd3, 5'd20, 64'h2020);
        step();
        chk("proto_set", {63'd0, proto_err}, 64'd1);
        set_pipe(1'b0, 2'd0, 5'd0, '0);
        for (int i = 0; i < 3; i++) step();
        chk("proto_sticky", {63'd0, proto_err}, 64'd1);

        // Reset with three queued entries.
        set_pipe(1'b1, 2'd0, 5'd0, '0);
        for (int i = 0; i < 3; i++) begin
            set_acc(1'b1, 2'(i), 5'(5 + i), 64'(32'h700 + i));
            step();
        end
        set_acc(1'b0, 2'd0, 5'd0, '0);
        set_pipe(1'b0, 2'd0, 5'd0, '0);
        reset = 1'b1;
        step();
        chk("rst_mid_ctrl", {63'd0, ctrl_WB}, 64'd0);
        chk("rst_mid_ready", {63'd0, acc_ready}, 64'd1);
        chk("rst_mid_proto", {63'd0, proto_err}, 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
